// File: rtl/wd_defs.sv
// Shared definitions for the AXI write-data channel manager:
// FSM encodings, default widths and the queued command entry.
package wd_defs;

  localparam int DATA_W_DEF = 32;
  localparam int ID_W_DEF   = 4;
  localparam int LEN_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    WAIT = 2'd2,
    DEFO = 2'd3
  } wd_state_e;

  typedef struct packed {
    logic [ID_W_DEF-1:0]  id;
    logic [LEN_W_DEF-1:0] len;
  } wd_cmd_t;

endpackage

// File: rtl/wd_cmd_fifo.sv
// Two-entry command FIFO holding {id,len} of accepted write addresses.
// Head is read combinationally, so a push and a pop may share a cycle even when full.
module wd_cmd_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/wdata_chan_mngr.sv
// Master-side AXI W channel manager: streams queued bursts from the source onto W,
// reports each burst's completion and holds off the next burst until its response.
//
// state | meaning
// IDLE  | no burst active; pop next command when one is queued
// DATA  | streaming beats of the current burst through the output register
// WAIT  | last beat sent; waiting for finish_wresp of this burst
// DEFO  | protocol error seen; sticky until reset
module wdata_chan_mngr
  import wd_defs::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ID_W   = ID_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_wd,
  input  logic [ID_W-1:0]     start_id,
  input  logic [LEN_W-1:0]    start_len,
  output logic                cmd_full,
  input  logic                src_valid,
  output logic                src_ready,
  input  logic [DATA_W-1:0]   src_data,
  input  logic [DATA_W/8-1:0] src_strb,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic [ID_W-1:0]     wid,
  output logic                finish_wd,
  output logic [ID_W-1:0]     finish_id,
  input  logic                finish_wresp,
  output logic                err
);

  wd_state_e        state;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             overflow;
  logic             load;
  logic             beat_done;
  logic [ID_W-1:0]  head_id;
  logic [LEN_W-1:0] head_len;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W:0]   fetch_cnt;

  assign pop       = (state == IDLE) && !fifo_empty;
  assign overflow  = start_wd && fifo_full && !pop;
  assign push      = start_wd && (state != DEFO) && (!fifo_full || pop);
  assign cmd_full  = fifo_full || (state == DEFO);
  assign src_ready = (state == DATA) && (fetch_cnt <= {1'b0, len_r}) && (!wvalid || wready);
  assign load      = src_valid && src_ready;
  assign beat_done = wvalid && wready;

  wd_cmd_fifo #(.W(ID_W + LEN_W)) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({start_id, start_len}),
    .pop   (pop),
    .dout  ({head_id, head_len}),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_r     <= '0;
      fetch_cnt <= '0;
      wvalid    <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      wlast     <= 1'b0;
      wid       <= '0;
      finish_wd <= 1'b0;
      finish_id <= '0;
      err       <= 1'b0;
    end else begin
      finish_wd <= 1'b0;
      // A stray response or a push into a full queue poisons the channel.
      if (overflow || (finish_wresp && state != WAIT)) begin
        state  <= DEFO;
        err    <= 1'b1;
        wvalid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!fifo_empty) begin
              wid       <= head_id;
              len_r     <= head_len;
              fetch_cnt <= '0;
              state     <= DATA;
            end
          end
          DATA: begin
            if (load) begin
              wdata     <= src_data;
              wstrb     <= src_strb;
              wvalid    <= 1'b1;
              wlast     <= (fetch_cnt == {1'b0, len_r});
              fetch_cnt <= fetch_cnt + (LEN_W+1)'(1);
            end else if (beat_done) begin
              wvalid <= 1'b0;
            end
            if (beat_done && wlast) begin
              finish_wd <= 1'b1;
              finish_id <= wid;
              state     <= WAIT;
            end
          end
          WAIT: begin
            if (finish_wresp) state <= IDLE;
          end
          DEFO: begin
            err    <= 1'b1;
            wvalid <= 1'b0;
          end
          default: state <= DEFO;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wdata_chan_mngr.sv
// Bench for wdata_chan_mngr: table of bursts plus hand sequences for queueing,
// response gating, error and reset corners; W beats checked against a scoreboard.
module tb_wdata_chan_mngr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_wd;
  logic [3:0]  start_id;
  logic [3:0]  start_len;
  logic        cmd_full;
  logic        src_valid;
  logic        src_ready;
  logic [31:0] src_data;
  logic [3:0]  src_strb;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic [3:0]  wid;
  logic        finish_wd;
  logic [3:0]  finish_id;
  logic        finish_wresp;
  logic        err;

  wdata_chan_mngr dut (
    .clk(clk), .rst_n(rst_n), .start_wd(start_wd), .start_id(start_id),
    .start_len(start_len), .cmd_full(cmd_full), .src_valid(src_valid),
    .src_ready(src_ready), .src_data(src_data), .src_strb(src_strb),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wid(wid), .finish_wd(finish_wd), .finish_id(finish_id),
    .finish_wresp(finish_wresp), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } beat_t;

  typedef struct {
    logic [3:0]  id;
    logic [3:0]  len;
    int          gap;
    int          mode;
    logic [31:0] base;
    logic [3:0]  strb;
    int          exp_beats;
    logic [3:0]  exp_fin;
  } vec_t;

  beat_t       exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          wr_mode = 0;
  int          fin_seen = 0;
  int          fin_target = 0;
  int          beat_cnt = 0;
  int          last_beats = 0;
  logic [3:0]  last_fin_id = '0;
  logic [3:0]  fin_id_exp = '0;
  logic        fin_exp = 1'b0;
  logic        have_fin = 1'b0;
  logic        prev_load = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_stall = 1'b0;
  logic [41:0] prev_w = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // wready pattern generator: 0 always ready, 1 alternating, 2 random, else never ready
  initial begin
    wready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (wr_mode)
        0:       wready = 1'b1;
        1:       wready = ~wready;
        2:       wready = 1'($urandom_range(0, 1));
        default: wready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_load  = 1'b0;
      prev_stall = 1'b0;
      fin_exp    = 1'b0;
      have_fin   = 1'b0;
      beat_cnt   = 0;
    end else begin
      if (prev_load) begin
        chk("w_latency_valid", 64'(wvalid), 64'(1));
        chk("w_latency_data", 64'(wdata), 64'(prev_data));
      end
      if (prev_stall)
        chk("w_stable", 64'({wvalid, wid, wdata, wstrb, wlast}), 64'(prev_w));
      if (fin_exp || finish_wd) chk("finish_wd", 64'(finish_wd), 64'(fin_exp));
      if (finish_wd) begin
        fin_seen++;
        last_fin_id = finish_id;
        have_fin = 1'b1;
        if (fin_exp) chk("finish_id", 64'(finish_id), 64'(fin_id_exp));
      end else if (have_fin) begin
        chk("finish_id_hold", 64'(finish_id), 64'(fin_id_exp));
      end
      fin_exp = 1'b0;
      if (wvalid && wready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat actual wid=%0h wdata=%0h required no beat", wid, wdata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("wid", 64'(wid), 64'(e.id));
          chk("wdata", 64'(wdata), 64'(e.data));
          chk("wstrb", 64'(wstrb), 64'(e.strb));
          chk("wlast", 64'(wlast), 64'(e.last));
          beat_cnt++;
          if (e.last) begin
            fin_exp    = 1'b1;
            fin_id_exp = e.id;
            last_beats = beat_cnt;
            beat_cnt   = 0;
          end
        end
      end
      prev_load  = src_valid && src_ready;
      prev_data  = src_data;
      prev_stall = wvalid && !wready;
      prev_w     = {1'b1, wid, wdata, wstrb, wlast};
    end
  end

  task automatic send_start(input logic [3:0] id, input logic [3:0] len);
    start_wd  = 1'b1;
    start_id  = id;
    start_len = len;
    tick();
    start_wd  = 1'b0;
  endtask

  task automatic source_burst(input logic [3:0] id, input logic [3:0] len, input int nbeats,
                              input int gap, input logic [31:0] base, input logic [3:0] strb);
    for (int i = 0; i < nbeats; i++) begin
      logic got;
      if (i > 0 && gap > 0) begin
        src_valid = 1'b0;
        repeat (gap) tick();
      end
      src_valid = 1'b1;
      src_data  = base + 32'(i);
      src_strb  = strb ^ 4'(i);
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
        @(negedge clk);
        if (src_ready) begin
          exp_q.push_back('{id, src_data, src_strb, (i == int'(len))});
          got = 1'b1;
        end
        tick();
      end
      chk("src_handshake", 64'(got), 64'(1));
    end
    src_valid = 1'b0;
  endtask

  task automatic wait_fin();
    fin_target++;
    for (int k = 0; k < 300 && fin_seen < fin_target; k++) tick();
    chk("finish_wait", 64'(fin_seen >= fin_target), 64'(1));
  endtask

  task automatic respond();
    finish_wresp = 1'b1;
    tick();
    finish_wresp = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic no_traffic(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      chk({name, "_src_ready"}, 64'(src_ready), 64'(0));
      chk({name, "_wvalid"}, 64'(wvalid), 64'(0));
      tick();
    end
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{4'd3,  4'd0,  0, 0, 32'hA5A5_0001, 4'hF, 1,  4'd3};
    vecs[1] = '{4'd5,  4'd3,  0, 1, 32'h5000_0010, 4'hE, 4,  4'd5};
    vecs[2] = '{4'd9,  4'd2,  2, 0, 32'h9000_0100, 4'h7, 3,  4'd9};
    vecs[3] = '{4'hF,  4'hF,  0, 2, 32'hF000_1000, 4'h3, 16, 4'hF};
    vecs[4] = '{4'd6,  4'd1,  1, 1, 32'h6000_0000, 4'h1, 2,  4'd6};

    rst_n = 1'b0; start_wd = 1'b0; start_id = '0; start_len = '0;
    src_valid = 1'b0; src_data = '0; src_strb = '0; finish_wresp = 1'b0;
    repeat (3) tick();
    chk("reset_outputs",
        64'({wvalid, wlast, wid, wdata, wstrb, finish_wd, finish_id, err, cmd_full, src_ready}), 64'(0));
    rst_n = 1'b1;
    tick();

    foreach (vecs[v]) begin
      wr_mode = vecs[v].mode;
      send_start(vecs[v].id, vecs[v].len);
      source_burst(vecs[v].id, vecs[v].len, int'(vecs[v].len) + 1, vecs[v].gap,
                   vecs[v].base, vecs[v].strb);
      wait_fin();
      chk("burst_beats", 64'(last_beats), 64'(vecs[v].exp_beats));
      chk("burst_fin_id", 64'(last_fin_id), 64'(vecs[v].exp_fin));
      respond();
      chk("burst_err", 64'(err), 64'(0));
    end

    // Queue two bursts behind one awaiting its response.
    wr_mode = 0;
    send_start(4'd4, 4'd0);
    source_burst(4'd4, 4'd0, 1, 0, 32'h4444_0000, 4'hF);
    wait_fin();
    send_start(4'd1, 4'd1);
    send_start(4'd2, 4'd0);
    chk("queue_full", 64'(cmd_full), 64'(1));
    no_traffic("gate_id1", 3);
    respond();
    chk("resp_idle_src_ready", 64'(src_ready), 64'(0));
    send_start(4'd8, 4'd0);
    chk("push_pop_full_err", 64'(err), 64'(0));
    chk("push_pop_full", 64'(cmd_full), 64'(1));
    chk("resp_data_src_ready", 64'(src_ready), 64'(1));
    source_burst(4'd1, 4'd1, 2, 0, 32'h1111_0000, 4'hC);
    wait_fin();
    chk("q_fin_id1", 64'(last_fin_id), 64'(1));
    no_traffic("gate_id2", 3);
    respond();
    source_burst(4'd2, 4'd0, 1, 0, 32'h2222_0000, 4'h5);
    wait_fin();
    chk("q_fin_id2", 64'(last_fin_id), 64'(2));
    respond();
    source_burst(4'd8, 4'd0, 1, 0, 32'h8888_0000, 4'hA);
    wait_fin();
    chk("q_fin_id8", 64'(last_fin_id), 64'(8));
    respond();
    chk("queue_drained", 64'(cmd_full), 64'(0));

    // Overflow of the command queue.
    send_start(4'd10, 4'd0);
    send_start(4'd11, 4'd0);
    send_start(4'd12, 4'd0);
    chk("ovf_pre_full", 64'(cmd_full), 64'(1));
    chk("ovf_pre_err", 64'(err), 64'(0));
    send_start(4'd13, 4'd0);
    chk("defo_state", 64'({err, cmd_full, wvalid, src_ready}), 64'(4'b1100));
    src_valid = 1'b1;
    repeat (4) tick();
    chk("defo_sticky", 64'({err, cmd_full, wvalid, src_ready}), 64'(4'b1100));
    src_valid = 1'b0;
    do_reset();
    chk("err_after_reset", 64'({err, cmd_full}), 64'(0));

    // Response with no burst outstanding.
    respond();
    chk("stray_resp_err", 64'({err, cmd_full}), 64'(2'b11));
    do_reset();

    // Reset while beat 2 of a 4-beat burst is on W.
    send_start(4'd14, 4'd3);
    source_burst(4'd14, 4'd3, 2, 0, 32'hE000_0000, 4'hF);
    rst_n = 1'b0;
    #1;
    chk("midburst_reset",
        64'({wvalid, wlast, finish_wd, err, cmd_full, src_ready}), 64'(0));
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    no_traffic("post_reset_empty", 3);
    send_start(4'd7, 4'd0);
    source_burst(4'd7, 4'd0, 1, 0, 32'h7777_0000, 4'h3);
    wait_fin();
    chk("post_reset_fin_id", 64'(last_fin_id), 64'(7));
    chk("post_reset_beats", 64'(last_beats), 64'(1));
    respond();
    chk("post_reset_err", 64'(err), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
